// File: rtl/handshake_fifo_break_dv_55.sv
// Elastic FIFO on a handshake channel that breaks data/valid and ready paths.
// Ports: clk, rst (sync, active-high); ins/ins_valid/ins_ready (producer side);
//        outs/outs_valid/outs_ready (consumer side). All outputs are registered.
module handshake_fifo_break_dv_55 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);

    localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic                  wr;
    logic                  rd;

    // Handshake outputs decode only registered state.
    assign ins_ready  = (count != FULL);
    assign outs_valid = (count != '0);
    assign outs       = mem[head];

    assign wr = ins_valid & ins_ready;
    assign rd = outs_valid & outs_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[tail] <= ins;
                // Explicit wrap so non-power-of-2 depths work.
                tail <= (tail == LAST) ? '0 : tail + PW'(1);
            end
            if (rd) begin
                head <= (head == LAST) ? '0 : head + PW'(1);
            end
            unique case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Producer must hold a stalled token unchanged until it is accepted.
    a_hold : assert property (
        @(posedge clk) disable iff (rst)
        (ins_valid && !ins_ready) |=> (ins_valid && $stable(ins))
    );

    a_bound : assert property (
        @(posedge clk) disable iff (rst)
        count <= FULL
    );

    a_no_under : assert property (
        @(posedge clk) disable iff (rst)
        (count == '0) |-> !rd
    );

endmodule

// File: tb/tb_handshake_fifo_break_dv_55.sv
// Self-checking bench for handshake_fifo_break_dv_55.
// Drives a 4-slot and a 3-slot instance with 13-bit tokens.
module tb_handshake_fifo_break_dv_55;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] ins = '0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [12:0] outs;
    logic        outs_valid;
    logic        outs_ready = 1'b0;

    logic        rst3 = 1'b1;
    logic [12:0] ins3 = '0;
    logic        ins_valid3 = 1'b0;
    logic        ins_ready3;
    logic [12:0] outs3;
    logic        outs_valid3;
    logic        outs_ready3 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    handshake_fifo_break_dv_55 #(.DATA_WIDTH(13), .NUM_SLOTS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    handshake_fifo_break_dv_55 #(.DATA_WIDTH(13), .NUM_SLOTS(3)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .ins        (ins3),
        .ins_valid  (ins_valid3),
        .ins_ready  (ins_ready3),
        .outs       (outs3),
        .outs_valid (outs_valid3),
        .outs_ready (outs_ready3)
    );

    typedef struct {
        logic        rst;
        logic [12:0] ins;
        logic        iv;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [12:0] e_outs;
        logic        c_outs;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic [12:0] d, logic iv,
                                logic ordy, logic ov, logic ir,
                                logic [12:0] eo, logic co);
        vec_t v;
        v.rst    = r;
        v.ins    = d;
        v.iv     = iv;
        v.ordy   = ordy;
        v.e_ov   = ov;
        v.e_ir   = ir;
        v.e_outs = eo;
        v.c_outs = co;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] q [$];
        logic [12:0] exp_tok;
        logic        wf;
        logic        rf;
        int          sent;
        int          popped;

        // reset, single token, fill/drain
        tbl[0]  = mk(1, 13'h0000, 0, 0, 0, 1, 13'h0000, 1);
        tbl[1]  = mk(1, 13'h0000, 0, 0, 0, 1, 13'h0000, 1);
        tbl[2]  = mk(0, 13'h0000, 0, 0, 0, 1, 13'h0000, 1);
        tbl[3]  = mk(0, 13'h0FAE, 1, 1, 1, 1, 13'h0FAE, 1);
        tbl[4]  = mk(0, 13'h0000, 0, 1, 0, 1, 13'h0000, 0);
        tbl[5]  = mk(0, 13'd1,    1, 0, 1, 1, 13'd1,    1);
        tbl[6]  = mk(0, 13'd2,    1, 0, 1, 1, 13'd1,    1);
        tbl[7]  = mk(0, 13'd3,    1, 0, 1, 1, 13'd1,    1);
        tbl[8]  = mk(0, 13'd4,    1, 0, 1, 0, 13'd1,    1);
        tbl[9]  = mk(0, 13'd5,    1, 0, 1, 0, 13'd1,    1);
        tbl[10] = mk(0, 13'd5,    1, 1, 1, 1, 13'd2,    1);
        tbl[11] = mk(0, 13'd5,    1, 1, 1, 1, 13'd3,    1);
        tbl[12] = mk(0, 13'd0,    0, 1, 1, 1, 13'd4,    1);
        tbl[13] = mk(0, 13'd0,    0, 1, 1, 1, 13'd5,    1);
        tbl[14] = mk(0, 13'd0,    0, 1, 0, 1, 13'd0,    0);

        for (int i = 0; i < NV; i++) begin
            rst        = tbl[i].rst;
            ins        = tbl[i].ins;
            ins_valid  = tbl[i].iv;
            outs_ready = tbl[i].ordy;
            tick();
            chk($sformatf("vec%0d_outs_valid", i), 32'(outs_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_ins_ready", i), 32'(ins_ready), 32'(tbl[i].e_ir));
            if (tbl[i].c_outs)
                chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tbl[i].e_outs));
        end

        // streaming 0..19
        outs_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ins       = 13'(k);
            ins_valid = 1'b1;
            tick();
            chk($sformatf("stream%0d_outs", k), 32'(outs), 32'(k));
            chk($sformatf("stream%0d_ov_ir", k), {30'd0, outs_valid, ins_ready}, 32'd3);
        end
        ins_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(outs_valid), 32'd0);

        // wrap-around on the 3-slot instance against a scoreboard
        tick();
        tick();
        rst3       = 1'b0;
        ins3       = 13'd100;
        ins_valid3 = 1'b1;
        sent       = 0;
        popped     = 0;
        for (int c = 0; c < 80; c++) begin
            outs_ready3 = (c < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
            wf = ins_valid3 && ins_ready3;
            rf = outs_valid3 && outs_ready3;
            chk("wrap_ov", 32'(outs_valid3), 32'(q.size() != 0));
            chk("wrap_ir", 32'(ins_ready3), 32'(q.size() != 3));
            if (rf && q.size() != 0) begin
                exp_tok = q.pop_front();
                chk("wrap_order", 32'(outs3), 32'(exp_tok));
                popped++;
            end
            if (wf) q.push_back(ins3);
            tick();
            if (wf) begin
                sent++;
                if (sent == 15) ins_valid3 = 1'b0;
                else ins3 = ins3 + 13'd1;
            end
        end
        chk("wrap_sent", 32'(sent), 32'd15);
        chk("wrap_popped", 32'(popped), 32'd15);

        // mid-operation reset discards stored tokens
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins        = 13'h111;
        tick();
        ins        = 13'h222;
        tick();
        ins        = 13'h333;
        tick();
        chk("mid_stored_outs", 32'(outs), 32'h111);
        ins_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst        = 1'b0;
        chk("mid_rst_ov", 32'(outs_valid), 32'd0);
        chk("mid_rst_ir", 32'(ins_ready), 32'd1);
        outs_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mid_idle%0d_ov", k), 32'(outs_valid), 32'd0);
        end
        ins       = 13'h444;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        chk("mid_new_outs", 32'(outs), 32'h444);
        chk("mid_new_ov", 32'(outs_valid), 32'd1);
        tick();
        chk("mid_new_gone", 32'(outs_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
